joy_dir_filter: RTL and testbench

- Multi-player joystick direction conditioner placed between hps_io joystick words and the core input-port mapping.
- Per player it synchronises, debounces and SOCD-cleans the 4 direction bits.
- It then applies a run-time restriction mode: 8-way pass, 4-way last-pressed, 4-way sticky-axis, or 2-way horizontal.
- It is the generalised successor of the single-player 4-way mask filter and replaces one instance per player.

---
 rtl/joy_dir_filter.sv | 160 ++++++++++++++++
 tb/tb_joy_dir_filter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/joy_dir_filter.sv
// Per-player joystick direction conditioner: synchronise, debounce, SOCD-clean,
// then restrict to 8-way, 4-way (last-pressed or sticky-axis) or 2-way output.
module joy_dir_filter #(
    parameter int PLAYERS     = 2,
    parameter int DEB_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce,
    input  logic [1:0]             mode,
    input  logic                   socd,
    input  logic [DEB_W-1:0]       deb_len,
    input  logic [4*PLAYERS-1:0]   indir,
    output logic [4*PLAYERS-1:0]   outdir,
    output logic [PLAYERS-1:0]     changed
);

    localparam int SS = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;

    function automatic logic [DEB_W-1:0] sat_inc(input logic [DEB_W-1:0] c);
        return (&c) ? c : c + DEB_W'(1);
    endfunction

    // Axis "last" encoding matches the {hi,lo} bit pair: 10 hi side, 01 lo side, 00 none.
    function automatic logic [1:0] last_next(input logic [1:0] rise, input logic [1:0] last);
        if (rise == 2'b11)      return 2'b00;
        else if (rise == 2'b10) return 2'b10;
        else if (rise == 2'b01) return 2'b01;
        else                    return last;
    endfunction

    function automatic logic [1:0] axis_clean(input logic [1:0] held, input logic [1:0] lastn,
                                              input logic socd_en);
        if (held == 2'b11) return socd_en ? lastn : 2'b00;
        else               return held;
    endfunction

    function automatic logic [3:0] hi_onehot(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else           return 4'b0001;
    endfunction

    logic [1:0] prev_mode;
    logic       mode_chg;

    assign mode_chg = (mode != prev_mode);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_mode <= 2'b00;
        else          prev_mode <= mode;
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [SS-1:0][3:0]      sync_p0;
        logic [3:0][DEB_W-1:0]   cnt_p1;
        logic [3:0]              db_p1;
        logic [3:0]              db_prev_p1;
        logic [1:0]              last_v_p1, last_h_p1;
        logic [1:0]              lastn_v, lastn_h;
        logic [3:0]              rise, cleaned, cleaned_prev_p2, newp;
        logic [3:0]              mask_p2, mask_nxt, outdir_p2, out_nxt;
        logic                    changed_p2;

        // Stage p0: synchroniser chain
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_p0 <= '0;
            end else begin
                sync_p0[0] <= indir[4*p +: 4];
                for (int s = 1; s < SS; s++) sync_p0[s] <= sync_p0[s-1];
            end
        end

        // Stage p1: per-bit debounce; a bit only moves after deb_len ce ticks of disagreement
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_p1 <= '0;
                db_p1  <= '0;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (deb_len == '0) begin
                        db_p1[b]  <= sync_p0[SS-1][b];
                        cnt_p1[b] <= '0;
                    end else if (sync_p0[SS-1][b] == db_p1[b]) begin
                        cnt_p1[b] <= '0;
                    end else if (ce) begin
                        if (sat_inc(cnt_p1[b]) >= deb_len) begin
                            db_p1[b]  <= sync_p0[SS-1][b];
                            cnt_p1[b] <= '0;
                        end else begin
                            cnt_p1[b] <= sat_inc(cnt_p1[b]);
                        end
                    end
                end
            end
        end

        assign rise    = db_p1 & ~db_prev_p1;
        assign lastn_v = last_next(rise[3:2], last_v_p1);
        assign lastn_h = last_next(rise[1:0], last_h_p1);
        assign cleaned = {axis_clean(db_p1[3:2], lastn_v, socd),
                          axis_clean(db_p1[1:0], lastn_h, socd)};
        assign newp    = cleaned & ~cleaned_prev_p2;

        always_comb begin
            mask_nxt = mask_p2;
            out_nxt  = cleaned;
            case (mode)
                2'b01: begin
                    // Output uses the mask from before this cycle's update (legacy timing).
                    out_nxt = cleaned & mask_p2;
                    if (newp != 4'b0000)                   mask_nxt = hi_onehot(newp);
                    else if ((cleaned & mask_p2) == 4'b0000) mask_nxt = 4'hF;
                end
                2'b10: begin
                    if ((|cleaned[3:2]) && (|cleaned[1:0])) begin
                        if ((|outdir_p2[1:0]) && !(|outdir_p2[3:2]))
                            out_nxt = {2'b00, cleaned[1:0]};
                        else
                            out_nxt = {cleaned[3:2], 2'b00};
                    end
                end
                2'b11:   out_nxt = cleaned & 4'b0011;
                default: out_nxt = cleaned;
            endcase
            if (mode_chg) begin
                mask_nxt = 4'hF;
                out_nxt  = 4'b0000;
            end
        end

        // Stage p2: SOCD history, restriction mask and registered outputs
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                db_prev_p1      <= '0;
                last_v_p1       <= '0;
                last_h_p1       <= '0;
                cleaned_prev_p2 <= '0;
                mask_p2         <= 4'hF;
                outdir_p2       <= '0;
                changed_p2      <= 1'b0;
            end else begin
                db_prev_p1      <= db_p1;
                last_v_p1       <= lastn_v;
                last_h_p1       <= lastn_h;
                cleaned_prev_p2 <= cleaned;
                mask_p2         <= mask_nxt;
                outdir_p2       <= out_nxt;
                changed_p2      <= (out_nxt != outdir_p2);
            end
        end

        assign outdir[4*p +: 4] = outdir_p2;
        assign changed[p]       = changed_p2;
    end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench for joy_dir_filter (PLAYERS=2, SYNC_STAGES=2 -> 4-clock latency).
module tb_joy_dir_filter;

    logic       clk;
    logic       reset_n;
    logic       ce;
    logic [1:0] mode;
    logic       socd;
    logic [7:0] deb_len;
    logic [7:0] indir;
    logic [7:0] outdir;
    logic [1:0] changed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ce_div = 0;
    logic [7:0] seen;

    joy_dir_filter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .mode    (mode),
        .socd    (socd),
        .deb_len (deb_len),
        .indir   (indir),
        .outdir  (outdir),
        .changed (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            ce = (ce_div <= 1) ? 1'b1 : ((cyc % ce_div) == ce_div - 1);
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; ce = 1'b1; mode = 2'b00; socd = 1'b0;
        deb_len = 8'd0; indir = 8'h69;

        // reset and latency
        step(3);
        chk("rst_out", outdir, 8'h00);
        chk("rst_chg", {6'd0, changed}, 8'h00);
        reset_n = 1'b1;
        step(3);
        chk("lat_pre", outdir, 8'h00);
        step(1);
        chk("lat_out", outdir, 8'h69);
        chk("lat_chg", {6'd0, changed}, 8'h03);
        step(1);
        chk("chg_once", {6'd0, changed}, 8'h00);

        // mode 01 last-pressed on P0 while P1 toggles down
        indir = 8'h00; step(4);
        chk("idle0", outdir, 8'h00);
        mode = 2'b01; step(2);
        indir = 8'h01; step(2);
        indir = 8'h41; step(2);
        chk("m01_right", {4'd0, outdir[3:0]}, 8'h01);
        indir = 8'h49; step(2);
        indir = 8'h09; step(2);
        chk("m01_up_lag", {4'd0, outdir[3:0]}, 8'h01);
        step(1);
        chk("m01_up", {4'd0, outdir[3:0]}, 8'h08);
        step(1);
        chk("m01_hold", {4'd0, outdir[3:0]}, 8'h08);
        indir = 8'h41; step(3);
        chk("m01_hold2", {4'd0, outdir[3:0]}, 8'h08);
        step(1);
        chk("m01_rel", outdir, 8'h40);
        step(1);
        chk("m01_back", outdir, 8'h41);
        chk("m01_chg", {6'd0, changed}, 8'h01);

        // mode change 01 -> 00
        mode = 2'b00; step(1);
        chk("mchg_zero", outdir, 8'h00);
        chk("mchg_chg1", {6'd0, changed}, 8'h03);
        step(1);
        chk("mchg_val", outdir, 8'h41);
        chk("mchg_chg2", {6'd0, changed}, 8'h03);
        step(1);
        chk("mchg_chg3", {6'd0, changed}, 8'h00);

        // SOCD
        indir = 8'h00; socd = 1'b1; step(5);
        indir = 8'h03; step(4);
        chk("socd_both_rise", outdir, 8'h00);
        step(2);
        chk("socd_both_hold", outdir, 8'h00);
        indir = 8'h00; step(4);
        indir = 8'h02; step(4);
        chk("socd1_left", outdir, 8'h02);
        indir = 8'h03; step(4);
        chk("socd1_last", outdir, 8'h01);
        step(2);
        chk("socd1_keep", outdir, 8'h01);
        indir = 8'h00; socd = 1'b0; step(4);
        indir = 8'h02; step(4);
        chk("socd0_left", outdir, 8'h02);
        indir = 8'h03; step(4);
        chk("socd0_cancel", outdir, 8'h00);

        // debounce: deb_len=3, ce every 4th clock
        indir = 8'h00; step(4);
        deb_len = 8'd3; ce_div = 4; cyc = 0;
        seen = 8'h00;
        indir = 8'h08;
        for (int i = 0; i < 8; i++) begin step(1); seen = seen | outdir; end
        indir = 8'h00;
        for (int i = 0; i < 12; i++) begin step(1); seen = seen | outdir; end
        chk("deb_glitch", seen, 8'h00);
        cyc = 0;
        indir = 8'h08; step(12);
        chk("deb_pre", outdir, 8'h00);
        step(1);
        chk("deb_hold", outdir, 8'h08);
        step(3);
        indir = 8'h00; deb_len = 8'd0; ce_div = 0; step(5);
        chk("deb_off", outdir, 8'h00);

        // mode 10 sticky-axis
        mode = 2'b10; step(2);
        indir = 8'h08; step(4);
        chk("m10_up", outdir, 8'h08);
        indir = 8'h0A; step(4);
        chk("m10_add_left", outdir, 8'h08);
        step(2);
        chk("m10_keep", outdir, 8'h08);
        indir = 8'h00; step(5);
        indir = 8'h0A; step(4);
        chk("m10_together", outdir, 8'h08);
        indir = 8'h00; step(5);
        indir = 8'h02; step(4);
        chk("m10_left", outdir, 8'h02);
        indir = 8'h0A; step(4);
        chk("m10_add_up", outdir, 8'h02);

        // mode 11 horizontal only
        indir = 8'h00; step(5);
        mode = 2'b11; step(2);
        indir = 8'h09; step(4);
        chk("m11_upright", outdir, 8'h01);

        // reset mid-operation
        indir = 8'h00; step(4);
        mode = 2'b00; step(2);
        indir = 8'h18; step(4);
        chk("pre_rst", outdir, 8'h18);
        reset_n = 1'b0; #1;
        chk("rst_async", outdir, 8'h00);
        step(2);
        reset_n = 1'b1; step(3);
        chk("rst2_pre", outdir, 8'h00);
        step(1);
        chk("rst2_out", outdir, 8'h18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
